// File: rtl/rr_arbiter4_pkg.sv
//------------------------------------------------------------------------------
// rr_arbiter4_pkg - shared state encodings and sizing for the rr_arbiter4 slice
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } state_t;

  // Rotation successor; wraps 3 -> 0 through the natural 2-bit overflow.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4_if.sv
//------------------------------------------------------------------------------
// rr_arbiter4_if - request/grant bundle between requesters and the arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en, req,
    input  grant, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output grant, gnt_idx, gnt_valid, timeout
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter4_dec2to4.sv
//------------------------------------------------------------------------------
// arb_dec2to4 - 2-to-4 one-hot decoder with enable; all-zero when disabled
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_dec2to4
  import rr_arbiter4_pkg::*;
(
  input  wire logic [IDX_W-1:0]   i_idx,
  input  wire logic               i_en,
  output logic      [NUM_REQ-1:0] o_onehot
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dec
    assign o_onehot[i] = i_en & (i_idx == IDX_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
//------------------------------------------------------------------------------
// rr_arbiter4 - registered 4-way round-robin arbiter with hold-until-release
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
)(
  input  wire logic       clk,
  input  wire logic       rst_n,
  rr_arbiter4_if.slave    bus
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_gnt_valid;
  logic               r_timeout;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_dec;

  // Scan from ptr+3 down to ptr so the nearest set bit to ptr wins last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[r_ptr + IDX_W'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + IDX_W'(k);
      end
    end
  end

  arb_dec2to4 u_dec (
    .i_idx    (w_winner),
    .i_en     (w_found),
    .o_onehot (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (!bus.en) begin
      r_state     <= IDLE;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_found) begin
            r_state     <= GRANT;
            r_gnt_idx   <= w_winner;
            r_grant     <= w_dec;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= CNT_W'(1);
          end else begin
            r_grant     <= '0;
            r_gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!bus.req[r_gnt_idx] || (r_hold_cnt >= CNT_W'(MAX_HOLD))) begin
            // Releasing holder drops to lowest priority for the next round.
            r_state     <= REL;
            r_grant     <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= next_idx(r_gnt_idx);
            r_timeout   <= bus.req[r_gnt_idx];
          end else begin
            r_hold_cnt  <= r_hold_cnt + CNT_W'(1);
            r_timeout   <= 1'b0;
          end
        end
        REL: begin
          r_state   <= IDLE;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_grant     <= '0;
          r_gnt_valid <= 1'b0;
          r_hold_cnt  <= '0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire
